// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Turns byte/half/word core accesses into aligned word-wide memory
//             transactions with byte enables, and returns extended load data.
//             The optional BUSY timeout is enabled by defining LSU_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_error,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  if (WORD_SIZE != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("load_store_unit: WORD_SIZE must be 32 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]           state;
  logic [1:0]           size_q;
  logic [1:0]           off_q;
  logic                 unsigned_q;
  logic                 we_q;

  logic                 legal;
  logic [3:0]           be_calc;
  logic [WORD_SIZE-1:0] wdata_calc;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] load_data;
  logic                 timeout_hit;

  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    legal      = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = '0;
    case (req_size)
      SZ_BYTE: begin
        legal      = 1'b1;
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        legal      = !req_addr[0];
        be_calc    = 4'b0011 << req_addr[1:0];
        wdata_calc = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        legal      = (req_addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
      default: legal = 1'b0;
    endcase
  end

  // Extraction uses the offset/size captured at accept, not the live request.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      SZ_BYTE: load_data = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cnt;

  // Fires on the BUSY cycle whose un-acked edge brings the count to the limit.
  assign timeout_hit = !mem_ack && (cnt == TIMEOUT_CYCLES[$clog2(TIMEOUT_CYCLES+1)-1:0] - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) begin
      cnt <= '0;
    end else if (!mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            off_q      <= req_addr[1:0];
            unsigned_q <= req_unsigned;
            we_q       <= req_we;
            if (legal) begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[WORD_SIZE-1:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack || timeout_hit) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            resp_valid <= 1'b1;
            resp_error <= !mem_ack;
            resp_rdata <= (mem_ack && !we_q) ? load_data : '0;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
